// File: rtl/ven_machine.sv
// Vending controller: one item priced 15, accepts 5/10 coins, returns change.
// Optional cancel/refund on in=11 is enabled by defining VEN_MACHINE_CANCEL_EN.
module ven_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  state_t     state_q, state_d;
  logic       out_q, out_d;
  logic [1:0] change_q, change_d;

  // Next state and the one-cycle dispense/change pulses for this edge
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = CHG_NONE;
    case (state_q)
      S0: begin
        case (in)
          COIN_5:  state_d = S5;
          COIN_10: state_d = S10;
          default: state_d = S0;
        endcase
      end
      S5: begin
        case (in)
          COIN_5:  state_d = S10;
          COIN_10: begin
            state_d = S0;
            out_d   = 1'b1;
          end
`ifdef VEN_MACHINE_CANCEL_EN
          COIN_CANCEL: begin
            state_d  = S0;
            change_d = CHG_5;
          end
`endif
          default: state_d = S5;
        endcase
      end
      S10: begin
        case (in)
          COIN_5: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          COIN_10: begin
            state_d  = S0;
            out_d    = 1'b1;
            change_d = CHG_5;
          end
`ifdef VEN_MACHINE_CANCEL_EN
          COIN_CANCEL: begin
            state_d  = S0;
            change_d = CHG_10;
          end
`endif
          default: state_d = S10;
        endcase
      end
      // Unreachable encoding: drop to empty credit rather than lock up
      default: state_d = S0;
    endcase
  end

  // State and output registers; reset discards any held credit without refund
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S0;
      out_q    <= 1'b0;
      change_q <= CHG_NONE;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign out    = out_q;
  assign change = change_q;

  logic unused_s;
  assign unused_s = (COIN_NONE == COIN_CANCEL);

endmodule

// File: tb/tb_ven_machine.sv
// Directed-vector bench for ven_machine; builds with or without VEN_MACHINE_CANCEL_EN.
`timescale 1ns/1ps
module tb_ven_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int n_vec  = 0;
  int n_miss = 0;

  ven_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got {out,change}=%b, expected %b", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, then sample the registered outputs just after that edge
  task automatic apply(input string tag, input logic r, input logic [1:0] c,
                       input logic eo, input logic [1:0] ec);
    rst = r;
    in  = c;
    @(posedge clk);
    #1;
    check_val(tag, {out, change}, {eo, ec});
  endtask

  initial begin
    rst = 1'b1;
    in  = 2'b00;

    // 1: three 5-coins
    apply("t1_rst",  1'b1, 2'b00, 1'b0, 2'b00);
    apply("t1_c1",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t1_c2",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t1_c3",   1'b0, 2'b01, 1'b1, 2'b00);
    apply("t1_after",1'b0, 2'b00, 1'b0, 2'b00);

    // 2: 10+10 gives change 5
    apply("t2_c1",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("t2_c2",   1'b0, 2'b10, 1'b1, 2'b01);
    apply("t2_after",1'b0, 2'b00, 1'b0, 2'b00);

    // back-to-back purchase with no idle gap: 10, 10 then 10, 5
    apply("bb_c1",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("bb_c2",   1'b0, 2'b10, 1'b1, 2'b01);
    apply("bb_c3",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("bb_c4",   1'b0, 2'b01, 1'b1, 2'b00);

    // 3: 5+10, then idle
    apply("t3_c1",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t3_c2",   1'b0, 2'b10, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) apply("t3_idle", 1'b0, 2'b00, 1'b0, 2'b00);

    // idle holds credit: 5, idle x4, 10 dispenses
    apply("hold_c1", 1'b0, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) apply("hold_idle", 1'b0, 2'b00, 1'b0, 2'b00);
    apply("hold_c2", 1'b0, 2'b10, 1'b1, 2'b00);

    // 4: reset mid-transaction discards credit and ignores the coin
    apply("t4_c1",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("t4_rst",  1'b1, 2'b01, 1'b0, 2'b00);
    apply("t4_p1",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t4_p2",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t4_p3",   1'b0, 2'b01, 1'b1, 2'b00);

    // 5: 11 in S10, S5 and S0
    apply("t5_c1",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t5_c2",   1'b0, 2'b01, 1'b0, 2'b00);
`ifdef VEN_MACHINE_CANCEL_EN
    apply("t5_cx10", 1'b0, 2'b11, 1'b0, 2'b10);
    apply("t5_n1",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t5_cx5",  1'b0, 2'b11, 1'b0, 2'b01);
    apply("t5_cx0",  1'b0, 2'b11, 1'b0, 2'b00);
    apply("t5_n2",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("t5_n3",   1'b0, 2'b10, 1'b1, 2'b01);
`else
    apply("t5_cx10", 1'b0, 2'b11, 1'b0, 2'b00);
    apply("t5_n1",   1'b0, 2'b01, 1'b1, 2'b00);
    apply("t5_c3",   1'b0, 2'b01, 1'b0, 2'b00);
    apply("t5_cx5",  1'b0, 2'b11, 1'b0, 2'b00);
    apply("t5_n2",   1'b0, 2'b10, 1'b1, 2'b00);
    apply("t5_cx0",  1'b0, 2'b11, 1'b0, 2'b00);
    apply("t5_n3",   1'b0, 2'b10, 1'b0, 2'b00);
    apply("t5_n4",   1'b0, 2'b10, 1'b1, 2'b01);
`endif

    // 6: nine consecutive 5-coins after reset
    apply("t6_rst",  1'b1, 2'b00, 1'b0, 2'b00);
    for (int i = 1; i <= 9; i++)
      apply("t6_run", 1'b0, 2'b01, (i % 3 == 0) ? 1'b1 : 1'b0, 2'b00);
    apply("t6_after",1'b0, 2'b00, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
